// File: rtl/rsync_retimer_seg_pkg.sv
// Shared types and helpers for the DAC segment retimer.
package rsync_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam logic [1:0] ATB_OFF  = 2'b00;
  localparam logic [1:0] ATB_CELL = 2'b01;
  localparam logic [1:0] ATB_STAT = 2'b10;
  localparam logic [1:0] ATB_RAMP = 2'b11;

  // Largest legal code: all thermometer cells on plus all binary bits set.
  function automatic int max_code(input int ntherm, input int nbin);
    return ntherm * (1 << nbin) + (1 << nbin) - 1;
  endfunction

  // Width needed to carry a code up to max_code().
  function automatic int code_w(input int ntherm, input int nbin);
    return nbin + $clog2(ntherm + 1);
  endfunction

endpackage

// File: rtl/rsync_retimer_seg_encoder.sv
// Splits a DAC code into unary thermometer MSB cells and binary LSB cells.
module rsync_seg_encoder #(
  parameter int NTHERM = 17,
  parameter int NBIN   = 7,
  parameter int CODE_W = 12
) (
  input  logic [CODE_W-1:0] code,
  output logic [NTHERM-1:0] therm,
  output logic [NBIN-1:0]   bin
);

  logic [CODE_W-NBIN-1:0] msb;

  assign msb = code[CODE_W-1:NBIN];
  assign bin = code[NBIN-1:0];

  // Cell i is on when the MSB count exceeds i.
  always_comb begin
    therm = '0;
    for (int i = 0; i < NTHERM; i++) begin
      therm[i] = (i < int'(msb));
    end
  end

endmodule

// File: rtl/rsync_retimer_seg.sv
// DAC data retimer: saturate, select test pattern, pipeline, encode to cells.
module rsync_retimer_seg
  import rsync_pkg::*;
#(
  parameter int NTHERM     = 17,
  parameter int NBIN       = 7,
  parameter int CODE_W     = code_w(NTHERM, NBIN),
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              pdb,
  input  logic [1:0]        mode,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_vld,
  input  logic              sat_clr,
  input  logic [1:0]        atb_ena,
  output logic [NTHERM-1:0] dataouttherm,
  output logic [NTHERM-1:0] dataoutthermb,
  output logic [NBIN-1:0]   dataoutbin,
  output logic [NBIN-1:0]   dataoutbinb,
  output logic              sat_flag,
  output logic              atb0,
  output logic              atb1
);

  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(max_code(NTHERM, NBIN));

  mode_e             mode_s;
  logic [CODE_W-1:0] code_pipe [PIPE_DEPTH];  // index 0 is the stage-0 sample
  logic [CODE_W-1:0] p0_next;
  logic [CODE_W-1:0] ramp_cnt, ramp_next;
  logic              tog_phase, tog_next;
  logic              wrap, wrap_next;
  logic              sat_set;
  logic [NTHERM-1:0] therm_enc, therm_pn;
  logic [NBIN-1:0]   bin_enc, bin_pn;
  logic              atb0_next, atb1_next;

  assign mode_s = mode_e'(mode);

  function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
    return (c > MAX_CODE) ? MAX_CODE : c;
  endfunction

  // Stage-0 source selection and pattern-generator next state.
  always_comb begin
    p0_next   = code_pipe[0];
    ramp_next = '0;
    tog_next  = 1'b0;
    wrap_next = 1'b0;
    case (mode_s)
      MODE_NORMAL: if (code_vld) p0_next = sat_code(code_in);
      MODE_RAMP: begin
        p0_next   = ramp_cnt;
        wrap_next = (ramp_cnt == MAX_CODE);
        ramp_next = wrap_next ? '0 : ramp_cnt + 1'b1;
      end
      MODE_TOGGLE: begin
        p0_next  = tog_phase ? '0 : MAX_CODE;
        tog_next = ~tog_phase;
      end
      default: ;
    endcase
  end

  assign sat_set = pdb && (mode_s == MODE_NORMAL) && code_vld && (code_in > MAX_CODE);

  // ---- stage 0 .. final stage: code pipeline, flushed to 0 on power-down
  always_ff @(posedge clkin or posedge rst) begin
    if (rst || !pdb) begin
      for (int i = 0; i < PIPE_DEPTH; i++) code_pipe[i] <= '0;
      therm_pn <= '0;
      bin_pn   <= '0;
    end else begin
      code_pipe[0] <= p0_next;
      for (int i = 1; i < PIPE_DEPTH; i++) code_pipe[i] <= code_pipe[i-1];
      therm_pn <= therm_enc;
      bin_pn   <= bin_enc;
    end
  end

  rsync_seg_encoder #(
    .NTHERM (NTHERM),
    .NBIN   (NBIN),
    .CODE_W (CODE_W)
  ) u_enc (
    .code  (code_pipe[PIPE_DEPTH-1]),
    .therm (therm_enc),
    .bin   (bin_enc)
  );

  // Ramp counter, toggle phase and wrap pulse; cleared by power-down.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      ramp_cnt  <= '0;
      tog_phase <= 1'b0;
      wrap      <= 1'b0;
    end else if (!pdb) begin
      ramp_cnt  <= '0;
      tog_phase <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      ramp_cnt  <= ramp_next;
      tog_phase <= tog_next;
      wrap      <= wrap_next;
    end
  end

  // Sticky saturation flag; a new set beats a simultaneous clear.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) sat_flag <= 1'b0;
    else     sat_flag <= sat_set | (sat_flag & ~sat_clr);
  end

  // Analog-test-bus monitor source select.
  always_comb begin
    atb0_next = 1'b0;
    atb1_next = 1'b0;
    case (atb_ena)
      ATB_CELL: begin atb0_next = therm_pn[0]; atb1_next = bin_pn[0]; end
      ATB_STAT: begin atb0_next = sat_flag;    atb1_next = pdb;       end
      ATB_RAMP: begin atb0_next = wrap;        atb1_next = (mode_s != MODE_NORMAL); end
      default: ;
    endcase
  end

  // Register the monitor bits so they never glitch.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      atb0 <= 1'b0;
      atb1 <= 1'b0;
    end else begin
      atb0 <= atb0_next;
      atb1 <= atb1_next;
    end
  end

  assign dataouttherm  = therm_pn;
  assign dataoutthermb = ~therm_pn;
  assign dataoutbin    = bin_pn;
  assign dataoutbinb   = ~bin_pn;

endmodule

// File: doc/rsync_retimer_seg.md
Name: rsync_retimer_seg

Overview:
Parametrised next-generation DAC data retimer. It takes one unsigned DAC code per clock and saturates it to the legal range. It splits the code into thermometer MSB cells and binary LSB cells, then retimes both through a PIPE_DEPTH-stage register pipeline to drive complementary cell outputs. It adds on-chip test-pattern modes (ramp, toggle, hold), a synchronous power-down flush, a sticky saturation flag and a digital analog-test-bus monitor mux. It sits between the DSP code path and the current-steering cell array.

Parameters:
NTHERM, 17, number of thermometer (unary MSB) cells; must be >= 1
NBIN, 7, number of binary LSB bits; must be >= 1
CODE_W, NBIN + $clog2(NTHERM+1), input code width (derived; not overridden)
PIPE_DEPTH, 2, register stages from the stage-0 sample to the outputs; must be >= 1

Ports:
clkin  in  1  sole clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
pdb  in  1  power-down bar; 0 = powered down (sampled synchronously)
mode  in  2  0 NORMAL, 1 RAMP, 2 TOGGLE, 3 HOLD
code_in  in  CODE_W  DAC code, unsigned
code_vld  in  1  code_in is valid this cycle (NORMAL mode only)
sat_clr  in  1  clears sat_flag
atb_ena  in  2  test-bus monitor select
dataouttherm  out  NTHERM  thermometer cells, true polarity
dataoutthermb  out  NTHERM  complement of dataouttherm
dataoutbin  out  NBIN  binary cells, true polarity
dataoutbinb  out  NBIN  complement of dataoutbin
sat_flag  out  1  sticky: a code above MAX_CODE was received
atb0  out  1  test-bus monitor bit 0
atb1  out  1  test-bus monitor bit 1

Behaviour:
- MAX_CODE = NTHERM*2^NBIN + 2^NBIN - 1. With the defaults this is 2303.
- Encoding of the stage-0 code c:
  - t = c >> NBIN.
  - dataouttherm[i] = (i < t) for i in 0..NTHERM-1.
  - dataoutbin = c[NBIN-1:0].
  - The complements are always exact bitwise inverses.
- Reset (async, rst=1):
  - All pipeline stages hold code 0, so dataouttherm=0, dataoutbin=0 and both complements are all-ones.
  - sat_flag=0, ramp counter=0, toggle phase=0, atb0=atb1=0.
- Stage-0 source, updated each cycle while pdb=1:
  - NORMAL: if code_vld, load min(code_in, MAX_CODE); otherwise hold.
  - RAMP: load the ramp counter. The counter increments by 1 per cycle and wraps from MAX_CODE to 0. The wrap cycle raises an internal 1-cycle wrap pulse.
  - TOGGLE: alternate MAX_CODE and 0 every cycle. The first value after entering TOGGLE is MAX_CODE.
  - HOLD: stage 0 keeps its value.
- Mode changes take effect at the next rising edge. Entering RAMP restarts the counter at 0.
- Latency: a code sampled into stage 0 at edge N appears on the outputs after edge N+PIPE_DEPTH. Outputs are registered; there is no combinational input-to-output path.
- Saturation:
  - code_in > MAX_CODE with code_vld=1 in NORMAL sets sat_flag at the same edge.
  - sat_flag stays set until sat_clr=1.
  - If a set and sat_clr occur in the same cycle, set wins.
- Power-down (pdb=0):
  - At the next edge, all stages (including stage 0) load code 0; the outputs show code 0 within 1 cycle.
  - The ramp counter and toggle phase reset to 0; sat_flag is retained.
  - After pdb returns to 1, the first new code reaches the outputs PIPE_DEPTH cycles after its stage-0 sample. The outputs read code 0 until then.
- atb_ena, registered with 1-cycle latency:
  - 00: atb0=0, atb1=0.
  - 01: atb0=dataouttherm[0], atb1=dataoutbin[0].
  - 10: atb0=sat_flag, atb1=pdb.
  - 11: atb0=ramp wrap pulse, atb1=(mode!=NORMAL).
- Reset asserted mid-operation clears everything immediately, regardless of mode or pdb.

Decomposition:
- Package rsync_pkg holds:
  - the mode enum (NORMAL, RAMP, TOGGLE, HOLD);
  - the atb_ena select constants;
  - a max_code(NTHERM, NBIN) function;
  - a code_w(NTHERM, NBIN) function.
- Sub-module rsync_seg_encoder: combinational; takes the code and produces the therm and bin vectors. It is instantiated once, at the final pipeline stage.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> dataouttherm=17'h00000, dataoutthermb=17'h1FFFF, dataoutbin=7'h00, dataoutbinb=7'h7F, sat_flag=0.
- Latency check, NORMAL, pdb=1: code_in=1237 with code_vld for 1 cycle -> exactly 2 cycles later dataouttherm=17'h001FF, dataoutbin=7'h55. The value holds while code_vld=0.
- Saturation: code_in=4095 with code_vld -> dataouttherm=17'h1FFFF, dataoutbin=7'h7F, sat_flag=1. With sat_clr and a new saturating code in the same cycle, sat_flag stays 1. sat_clr alone -> sat_flag=0.
- RAMP with atb_ena=11: the outputs count 0,1,2,… with 2-cycle latency. After 2303 the next code is 0, and atb0 pulses high for exactly 1 cycle.
- TOGGLE then pdb drop: the outputs alternate 2303/0 starting at 2303. pdb=0 -> the outputs read code 0 within 1 cycle. pdb=1 -> the toggle restarts at 2303 after 2 cycles.
- Parameter sweep: NTHERM=15, NBIN=4, PIPE_DEPTH=1, code_in=255 -> 1-cycle latency, dataouttherm=15'h7FFF, dataoutbin=4'hF, no saturation.
